uart_baud_gen: RTL and testbench

Parametrised baud-rate generator for the UART. It produces independent single-cycle tick pulses for the TX path and a 16x (parametrised) oversampling tick for the RX path, plus RX bit-phase strobes. The RX phase can be re-aligned to a detected start-bit edge. Each path selects one of four preset rates or a runtime-programmed divisor. The block sits between the system clock and the UART TX/RX state machines.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/baud_div_counter.sv | 32 +++
 rtl/uart_baud_gen.sv | 102 ++++++++++
 tb/tb_uart_baud_gen.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART: rate-select encoding, preset baud rates and
// the elaboration-time divisor calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        BAUD_9600    = 3'd0,
        BAUD_19200   = 3'd1,
        BAUD_460800  = 3'd2,
        BAUD_1500000 = 3'd3,
        BAUD_CUSTOM  = 3'd4
    } baud_sel_e;

    localparam longint BAUD_RATE_9600    = 9600;
    localparam longint BAUD_RATE_19200   = 19200;
    localparam longint BAUD_RATE_460800  = 460800;
    localparam longint BAUD_RATE_1500000 = 1500000;

    // Counter terminal value for a rate: round(clk_hz / (baud * os)) - 1.
    function automatic longint baud_div(input longint clk_hz, input longint baud, input longint os);
        longint den;
        den = baud * os;
        return ((clk_hz + den / 2) / den) - 1;
    endfunction

endpackage

// File: rtl/baud_div_counter.sv
// Free-running divide-by-(div+1) counter emitting a registered one-cycle tick
// on each wrap. Reset, clear and disable all force the count back to 0.
module baud_div_counter #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_reg;
    logic             tick_reg;

    always_ff @(posedge clk) begin
        if (rst || clr || !en) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (cnt_reg == div) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b1;
        end else begin
            cnt_reg  <= cnt_reg + 1'b1;
            tick_reg <= 1'b0;
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud generator: TX bit tick, RX oversample tick and RX mid/end-of-bit
// strobes, with per-path divisor selection and RX phase realignment.
module uart_baud_gen #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int OVERSAMPLE  = 16,
    parameter int DIV_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       baud_sel,
    input  logic [DIV_W-1:0] div_custom_tx,
    input  logic [DIV_W-1:0] div_custom_rx,
    input  logic             rx_resync,
    output logic             tx_tick,
    output logic             rx_tick,
    output logic             rx_mid,
    output logic             rx_bit
);
    import uart_pkg::*;

    localparam int                OS_W    = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0]   OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]   OS_LAST = OS_W'(OVERSAMPLE - 1);

    logic [1:0]      path_changed;
    logic [1:0]      path_tick;
    logic            div_change;
    logic [OS_W-1:0] os_cnt_reg;

    // Any divisor change on either path restarts both, keeping TX and RX aligned.
    assign div_change = |path_changed;

    // Path 0 is TX (one tick per bit), path 1 is RX (OVERSAMPLE ticks per bit).
    for (genvar gi = 0; gi < 2; gi++) begin : g_path
        localparam longint OS_F = (gi == 0) ? longint'(1) : longint'(OVERSAMPLE);
        localparam logic [DIV_W-1:0] DIV_0 =
            DIV_W'(baud_div(longint'(CLK_FREQ_HZ), BAUD_RATE_9600, OS_F));
        localparam logic [DIV_W-1:0] DIV_1 =
            DIV_W'(baud_div(longint'(CLK_FREQ_HZ), BAUD_RATE_19200, OS_F));
        localparam logic [DIV_W-1:0] DIV_2 =
            DIV_W'(baud_div(longint'(CLK_FREQ_HZ), BAUD_RATE_460800, OS_F));
        localparam logic [DIV_W-1:0] DIV_3 =
            DIV_W'(baud_div(longint'(CLK_FREQ_HZ), BAUD_RATE_1500000, OS_F));

        logic [DIV_W-1:0] div_custom;
        logic [DIV_W-1:0] div_next;
        logic [DIV_W-1:0] div_q_reg;
        logic             path_clr;

        assign div_custom = (gi == 0) ? div_custom_tx : div_custom_rx;

        always_comb begin
            div_next = div_custom;
            case (baud_sel_e'(baud_sel))
                BAUD_9600:    div_next = DIV_0;
                BAUD_19200:   div_next = DIV_1;
                BAUD_460800:  div_next = DIV_2;
                BAUD_1500000: div_next = DIV_3;
                default:      div_next = div_custom;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                div_q_reg <= '0;
            end else begin
                div_q_reg <= div_next;
            end
        end

        assign path_changed[gi] = (div_q_reg != div_next);
        assign path_clr         = div_change || ((gi == 1) && rx_resync);

        baud_div_counter #(
            .DIV_W(DIV_W)
        ) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .clr  (path_clr),
            .en   (en),
            .div  (div_q_reg),
            .tick (path_tick[gi])
        );
    end

    // os_cnt counts RX ticks already seen in the current bit, so it still holds
    // the pre-advance value while the tick it qualifies is on the output.
    always_ff @(posedge clk) begin
        if (rst || !en || div_change || rx_resync) begin
            os_cnt_reg <= '0;
        end else if (rx_tick) begin
            os_cnt_reg <= (os_cnt_reg == OS_LAST) ? '0 : os_cnt_reg + 1'b1;
        end
    end

    assign tx_tick = path_tick[0];
    assign rx_tick = path_tick[1];
    assign rx_mid  = path_tick[1] && (os_cnt_reg == OS_MID);
    assign rx_bit  = path_tick[1] && (os_cnt_reg == OS_LAST);

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: cycle-accurate arithmetic model plus
// directed period/phase checks at the default 100 MHz, 16x configuration.
module tb_uart_baud_gen;

    localparam int OS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        rx_resync = 1'b0;
    logic [2:0]  baud_sel = 3'd0;
    logic [15:0] div_custom_tx = 16'd0;
    logic [15:0] div_custom_rx = 16'd0;
    logic        tx_tick, rx_tick, rx_mid, rx_bit;

    int     n_cmp = 0;
    int     n_err = 0;
    longint cyc = 0;

    // Model state: loaded divisors and the edge at which each path last restarted.
    longint dq_tx = 0, dq_rx = 0, o_tx = 0, o_rx = 0;
    logic [3:0] exp_out = 4'b0000;

    longint tx_last = -1, tx_prev = -1, rx_last = -1, rx_prev = -1;
    longint bit_last = -1, bit_prev = -1, mid_off = -1;

    uart_baud_gen #(
        .CLK_FREQ_HZ(100_000_000),
        .OVERSAMPLE (16),
        .DIV_W      (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .baud_sel     (baud_sel),
        .div_custom_tx(div_custom_tx),
        .div_custom_rx(div_custom_rx),
        .rx_resync    (rx_resync),
        .tx_tick      (tx_tick),
        .rx_tick      (rx_tick),
        .rx_mid       (rx_mid),
        .rx_bit       (rx_bit)
    );

    always #5 clk = ~clk;

    function automatic longint exp_div(input logic [2:0] sel, input logic [15:0] custom, input bit is_rx);
        longint tx_tab[4] = '{10416, 5207, 216, 66};
        longint rx_tab[4] = '{650, 325, 13, 3};
        if (sel >= 3'd4) return longint'(custom);
        return is_rx ? rx_tab[sel[1:0]] : tx_tab[sel[1:0]];
    endfunction

    task automatic check(input string name, input longint got, input longint want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Model update at each rising edge, comparison at the following falling edge.
    initial begin
        longint ntx, nrx, dt, dr, k;
        bit chg;
        forever begin
            @(posedge clk);
            cyc++;
            ntx = exp_div(baud_sel, div_custom_tx, 1'b0);
            nrx = exp_div(baud_sel, div_custom_rx, 1'b1);
            if (rst) begin
                dq_tx = 0; dq_rx = 0; o_tx = cyc; o_rx = cyc;
            end else begin
                chg = (ntx != dq_tx) || (nrx != dq_rx);
                dq_tx = ntx; dq_rx = nrx;
                if (!en || chg) begin
                    o_tx = cyc; o_rx = cyc;
                end else if (rx_resync) begin
                    o_rx = cyc;
                end
            end
            dt = cyc - o_tx;
            dr = cyc - o_rx;
            exp_out = 4'b0000;
            if (dt > 0 && (dt % (dq_tx + 1)) == 0) exp_out[3] = 1'b1;
            if (dr > 0 && (dr % (dq_rx + 1)) == 0) begin
                k = dr / (dq_rx + 1);
                exp_out[2] = 1'b1;
                exp_out[1] = ((k % OS) == OS / 2);
                exp_out[0] = ((k % OS) == 0);
            end
            @(negedge clk);
            n_cmp++;
            if ({tx_tick, rx_tick, rx_mid, rx_bit} !== exp_out) begin
                n_err++;
                $display("FAIL model cycle %0d: {tx,rx,mid,bit} got %b expected %b",
                         cyc, {tx_tick, rx_tick, rx_mid, rx_bit}, exp_out);
            end
            if (tx_tick) begin tx_prev = tx_last; tx_last = cyc; end
            if (rx_tick) begin rx_prev = rx_last; rx_last = cyc; end
            if (rx_mid) mid_off = cyc - bit_last;
            if (rx_bit) begin bit_prev = bit_last; bit_last = cyc; end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_for(input int which, input int max_cyc, output longint at);
        logic [3:0] v;
        at = -1;
        for (int i = 0; i < max_cyc; i++) begin
            step();
            v = {tx_tick, rx_tick, rx_mid, rx_bit};
            if (v[3 - which]) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        longint at, t, c, e, tx_before;

        run(5);
        check("reset_outputs", longint'({tx_tick, rx_tick, rx_mid, rx_bit}), 0);
        en = 1'b1;
        rst = 1'b0;

        run(21000);
        check("sel0_tx_period", tx_last - tx_prev, 10417);
        check("sel0_rx_period", rx_last - rx_prev, 651);
        check("sel0_bit_period", bit_last - bit_prev, 10416);
        check("sel0_mid_offset", mid_off, 5208);

        baud_sel = 3'd1;
        run(10600);
        check("sel1_tx_period", tx_last - tx_prev, 5208);
        check("sel1_rx_period", rx_last - rx_prev, 326);

        baud_sel = 3'd2;
        run(600);
        check("sel2_tx_period", tx_last - tx_prev, 217);
        check("sel2_rx_period", rx_last - rx_prev, 14);

        baud_sel = 3'd3;
        run(300);
        check("sel3_tx_period", tx_last - tx_prev, 67);
        check("sel3_rx_period", rx_last - rx_prev, 4);

        div_custom_tx = 16'd0;
        div_custom_rx = 16'd1;
        baud_sel = 3'd4;
        run(100);
        check("cust_tx_period", tx_last - tx_prev, 1);
        check("cust_rx_period", rx_last - rx_prev, 2);
        check("cust_bit_period", bit_last - bit_prev, 32);
        baud_sel = 3'd7;
        run(40);
        check("sel7_bit_period", bit_last - bit_prev, 32);

        // Rate switch 2 -> 3 part-way through a period.
        baud_sel = 3'd2;
        run(150);
        baud_sel = 3'd3;
        c = cyc + 1;
        wait_for(0, 200, at);
        check("switch_first_tx", at - c, 67);

        // Resync at an arbitrary point.
        run(23);
        tx_before = tx_last;
        rx_resync = 1'b1;
        t = cyc + 1;
        step();
        rx_resync = 1'b0;
        wait_for(2, 100, at);
        check("resync_mid", at - t, 32);
        wait_for(3, 100, at);
        check("resync_bit", at - t, 64);
        check("resync_tx_phase", (tx_last - tx_before) % 67, 0);

        // Resync landing exactly on an RX wrap suppresses that tick.
        wait_for(1, 20, e);
        run(3);
        rx_resync = 1'b1;
        step();
        rx_resync = 1'b0;
        check("resync_on_wrap_tick", longint'(rx_tick), 0);
        wait_for(1, 20, at);
        check("resync_on_wrap_next", at - (e + 4), 4);

        // Reset mid-period, then disable for 10 cycles.
        run(30);
        rst = 1'b1;
        step();
        check("reset_mid_outputs", longint'({tx_tick, rx_tick, rx_mid, rx_bit}), 0);
        run(2);
        rst = 1'b0;
        run(20);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("disabled_outputs", longint'({tx_tick, rx_tick, rx_mid, rx_bit}), 0);
        end
        en = 1'b1;
        run(150);
        check("resume_tx_period", tx_last - tx_prev, 67);
        check("resume_rx_period", rx_last - rx_prev, 4);
        check("resume_bit_period", bit_last - bit_prev, 64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
